led_blinker: RTL and testbench

LED_BLINKER -- requirements
Module: led_blinker

---
 rtl/led_pkg.sv | 14 +
 rtl/blink_timer.sv | 26 ++
 rtl/led_blinker.sv | 110 +++++++++++
 tb/tb_led_blinker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared FSM state type and default timing constants for the LED blinker.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int unsigned DEF_ON_CYCLES  = 4;
  localparam int unsigned DEF_OFF_CYCLES = 2;
  localparam int unsigned DEF_CNT_W      = 4;

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module blink_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_blinker.sv
// Request-queued LED blinker: ON/OFF phases timed by one shared blink_timer.
// Define LED_BLINKER_OVF_FLAG_EN to add the sticky ovf output for dropped requests.
module led_blinker
  import led_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_n,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending
`ifdef LED_BLINKER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0]    ON_LD    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]    OFF_LD   = TW'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t            state, state_next;
  logic              req;
  logic              start;
  logic              load;
  logic [TW-1:0]     load_val;
  logic              done;
  logic [CNT_W-1:0]  pending_next;

  assign req = ~pulse_n;

  blink_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      led     <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_next;
      led     <= (state_next == ON);
      busy    <= (state_next != IDLE);
      pending <= pending_next;
    end
  end

  // At the end of OFF a request arriving on that very edge is started directly,
  // so back-to-back blinks never pass through IDLE.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    unique case (state)
      IDLE: start = (pending != '0);
      ON: begin
        if (done) begin
          state_next = OFF;
          load       = 1'b1;
          load_val   = OFF_LD;
        end
      end
      OFF: begin
        if (done) begin
          if (pending != '0 || req) start = 1'b1;
          else                      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      state_next = ON;
      load       = 1'b1;
      load_val   = ON_LD;
    end
  end

  always_comb begin
    pending_next = pending;
    if (req && !start) begin
      if (pending != PEND_MAX) pending_next = pending + CNT_W'(1);
    end else if (!req && start) begin
      pending_next = pending - CNT_W'(1);
    end
  end

`ifdef LED_BLINKER_OVF_FLAG_EN
  logic drop;
  assign drop = req && !start && (pending == PEND_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_led_blinker.sv
// Scoreboarded bench for led_blinker; cycle model predicts led/busy/pending/ovf per edge.
module tb_led_blinker;

  localparam int unsigned ON   = 4;
  localparam int unsigned OFF  = 2;
  localparam int unsigned CW   = 4;
  localparam int          PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_n = 1'b1;
  logic          led, busy;
  logic [CW-1:0] pending;
`ifdef LED_BLINKER_OVF_FLAG_EN
  logic          ovf;
`endif

  led_blinker #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_n (pulse_n),
    .led     (led),
    .busy    (busy),
    .pending (pending)
`ifdef LED_BLINKER_OVF_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic led;
    logic busy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   m_state = 0, m_left = 0, m_pend = 0, m_blinks = 0;
  bit   m_ovf = 1'b0;
  int   dut_blinks = 0, peak = 0, b0 = 0, mb0 = 0;
  logic prev_led = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_state 0=IDLE 1=ON 2=OFF; m_left counts cycles left in the phase.
  task automatic model_step(input bit req);
    bit go = 1'b0;
    case (m_state)
      0: go = (m_pend > 0);
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_state = 2;
          m_left  = OFF;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_pend > 0 || req) go = 1'b1;
          else                   m_state = 0;
        end
      end
    endcase
    if (go) begin
      m_state = 1;
      m_left  = ON;
      m_blinks++;
    end
    m_pend = m_pend + int'(req) - int'(go);
    if (m_pend > PMAX) begin
      m_pend = PMAX;
      m_ovf  = 1'b1;
    end
  endtask

  // Entered at a negedge; drives one edge, checks after it, returns at next negedge.
  task automatic cycle(input bit req);
    exp_t e;
    pulse_n = ~req;
    model_step(req);
    e.led  = (m_state == 1);
    e.busy = (m_state != 0);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("led", 32'(led), 32'(e.led));
    check_eq("busy", 32'(busy), 32'(e.busy));
    check_eq("pending", 32'(pending), e.pend);
`ifdef LED_BLINKER_OVF_FLAG_EN
    check_eq("ovf", 32'(ovf), 32'(e.ovf));
`endif
    if (led && !prev_led) dut_blinks++;
    prev_led = led;
    if (int'(pending) > peak) peak = int'(pending);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    #2;
    rst_n   = 1'b0;
    pulse_n = 1'b1;
    #1;
    check_eq("rst_led", 32'(led), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_pending", 32'(pending), 0);
`ifdef LED_BLINKER_OVF_FLAG_EN
    check_eq("rst_ovf", 32'(ovf), 0);
`endif
    m_state  = 0;
    m_left   = 0;
    m_pend   = 0;
    m_ovf    = 1'b0;
    prev_led = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Single request: led high four edges, low two, then idle.
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    repeat (10) cycle(1'b0);

    // Three spaced pulses queue up behind the first blink.
    b0 = dut_blinks; peak = 0;
    cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b1);
    repeat (20) cycle(1'b0);
    check_eq("peak_pending", peak, 2);
    check_eq("three_blinks", dut_blinks - b0, 3);

    // Request on the last OFF edge restarts without an IDLE cycle.
    b0 = dut_blinks;
    cycle(1'b1);
    repeat (6) cycle(1'b0);
    cycle(1'b1);
    repeat (15) cycle(1'b0);
    check_eq("b2b_blinks", dut_blinks - b0, 2);

    // Long low run saturates the request counter.
    b0 = dut_blinks; mb0 = m_blinks; peak = 0;
    repeat (25) cycle(1'b1);
    repeat (200) cycle(1'b0);
    check_eq("sat_peak", peak, PMAX);
    check_eq("sat_blinks", dut_blinks - b0, m_blinks - mb0);

    // Reset during ON with three queued requests.
    apply_reset();
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b1);
    check_eq("pre_rst_pending", 32'(pending), 3);
    apply_reset();
    b0 = dut_blinks;
    repeat (20) cycle(1'b0);
    check_eq("no_blink_after_rst", dut_blinks - b0, 0);
    cycle(1'b1);
    repeat (10) cycle(1'b0);

    // Random request traffic.
    repeat (300) cycle($urandom_range(0, 3) == 0);
    repeat (30) cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
